ltc2333_read: RTL and testbench

LTC2333_READ -- requirements
Module: ltc2333_read

---
 rtl/ltc2333_read.sv | 184 ++++++++++++++++++
 tb/tb_ltc2333_read.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2333_read.sv
// LTC2333 read controller: starts a conversion, waits for it to finish (timer or BUSY),
// clocks 24 bits in MSB first on scki and holds the word until a valid/ready handshake.
module ltc2333_read #(
  parameter int unsigned BUSY_SIGNAL  = 0,
  parameter int unsigned BUSY_TIME    = 550,
  parameter int unsigned CLOCK_PERIOD = 20,
  parameter int unsigned SCK_HALF     = 1
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        busy,
  input  logic        sdo,
  output logic        cnv,
  output logic        scki,
  output logic [23:0] data_out,
  output logic        data_valid,
  input  logic        data_ready
);

  localparam int unsigned WORD_W       = 24;
  localparam int unsigned CONV_CYC_RAW = (BUSY_TIME + CLOCK_PERIOD - 1) / CLOCK_PERIOD;
  localparam int unsigned CONV_CYC     = (CONV_CYC_RAW == 0) ? 1 : CONV_CYC_RAW;
  localparam int unsigned TIMEOUT_CYC  = 2 * CONV_CYC;
  localparam int unsigned WCNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNV_CYC      = 2;
  localparam int unsigned BIT_W        = 5;
  localparam int unsigned HALF_W       = 8;

  localparam logic [WCNT_W-1:0] CNV_LAST     = WCNT_W'(CNV_CYC - 1);
  localparam logic [WCNT_W-1:0] CONV_LAST    = WCNT_W'(CONV_CYC - 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_LAST    = HALF_W'(SCK_HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(WORD_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CNV   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic              cnv_q,      cnv_d;
  logic              scki_q,     scki_d;
  logic [WORD_W-1:0] data_q,     data_d;
  logic              valid_q,    valid_d;
  logic [WORD_W-1:0] shreg_q,    shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              seen_q,     seen_d;
  logic              busy_s1_q,  busy_s2_q;
  logic              wait_done;

  // State and datapath registers; reset also kills scki mid-word
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      cnv_q      <= 1'b0;
      scki_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      wait_cnt_q <= '0;
      seen_q     <= 1'b0;
      busy_s1_q  <= 1'b0;
      busy_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnv_q      <= cnv_d;
      scki_q     <= scki_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      seen_q     <= seen_d;
      busy_s1_q  <= busy;
      busy_s2_q  <= busy_s1_q;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnv_d      = cnv_q;
    scki_d     = scki_q;
    data_d     = data_q;
    valid_d    = valid_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    half_cnt_d = half_cnt_q;
    wait_cnt_d = wait_cnt_q;
    seen_d     = seen_q;
    wait_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnv_d  = 1'b0;
        scki_d = 1'b0;
        if (enable && !valid_q) begin
          state_d    = S_CNV;
          cnv_d      = 1'b1;
          wait_cnt_d = '0;
        end
      end

      S_CNV: begin
        if (wait_cnt_q == CNV_LAST) begin
          state_d    = S_WAIT;
          cnv_d      = 1'b0;
          wait_cnt_d = '0;
          seen_d     = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        if (BUSY_SIGNAL != 0) begin
          // The timeout also covers a BUSY line that rises but never falls
          if (busy_s2_q) seen_d = 1'b1;
          wait_done = (seen_q && !busy_s2_q) || (wait_cnt_q == TIMEOUT_LAST);
        end else begin
          wait_done = (wait_cnt_q == CONV_LAST);
        end
        if (wait_done) begin
          state_d    = S_SHIFT;
          wait_cnt_d = '0;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          scki_d     = 1'b0;
        end
      end

      S_SHIFT: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          if (!scki_q) begin
            scki_d  = 1'b1;
            shreg_d = {shreg_q[WORD_W-2:0], sdo};
          end else begin
            scki_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              data_d    = shreg_q;
              valid_d   = 1'b1;
              state_d   = S_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
      end

      S_HOLD: begin
        if (valid_q && data_ready) begin
          valid_d = 1'b0;
          if (enable) begin
            state_d    = S_CNV;
            cnv_d      = 1'b1;
            wait_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cnv        = cnv_q;
  assign scki       = scki_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_ltc2333_read.sv
// Bench for ltc2333_read: a timer-mode instance (defaults) and a BUSY-mode instance with
// SCK_HALF = 3, each driven by a behavioural ADC model and checked by a scoreboard monitor.
module tb_ltc2333_read;

  localparam int SH_A = 1;
  localparam int SH_B = 3;
  localparam int TN   = 28;  // ceil(550/20)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic busy0 = 1'b0, busy1 = 1'b0;
  logic sdo0 = 1'b0, sdo1 = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b0;
  int   force0 = 0, force1 = 0;  // -1 random ready, else fixed level

  wire [1:0]       cnv_w, scki_w, dv_w;
  wire [1:0][23:0] dout_w;

  ltc2333_read u_dut_a (
    .clk(clk), .aresetn(rst_n), .enable(en0), .busy(busy0), .sdo(sdo0),
    .cnv(cnv_w[0]), .scki(scki_w[0]), .data_out(dout_w[0]), .data_valid(dv_w[0]),
    .data_ready(rdy0)
  );

  ltc2333_read #(.BUSY_SIGNAL(1), .SCK_HALF(SH_B)) u_dut_b (
    .clk(clk), .aresetn(rst_n), .enable(en1), .busy(busy1), .sdo(sdo1),
    .cnv(cnv_w[1]), .scki(scki_w[1]), .data_out(dout_w[1]), .data_valid(dv_w[1]),
    .data_ready(rdy1)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ADC models: word chosen at cnv rise, MSB first, next bit after each scki fall
  logic [23:0] adc_q0[$], adc_q1[$], exp_q0[$], exp_q1[$];
  logic [23:0] cur0, cur1;
  int idx0, idx1;

  always @(posedge cnv_w[0]) begin
    cur0 = (adc_q0.size() > 0) ? adc_q0.pop_front() : 24'($urandom);
    exp_q0.push_back(cur0);
    idx0 = 23;
    sdo0 = cur0[23];
  end
  always @(negedge scki_w[0]) begin
    idx0--;
    if (idx0 >= 0) sdo0 = cur0[5'(idx0)];
  end

  always @(posedge cnv_w[1]) begin
    cur1 = (adc_q1.size() > 0) ? adc_q1.pop_front() : 24'($urandom);
    exp_q1.push_back(cur1);
    idx1 = 23;
    sdo1 = cur1[23];
  end
  always @(negedge scki_w[1]) begin
    idx1--;
    if (idx1 >= 0) sdo1 = cur1[5'(idx1)];
  end

  // BUSY model for instance B: 10-cycle pulse, or stuck low to force the timeout
  int bmode_q[$];
  int bm;
  logic bp_valid = 1'b0;
  int bp_rise = 0;
  always @(posedge cnv_w[1]) begin
    bm = (bmode_q.size() > 0) ? bmode_q.pop_front() : int'($urandom_range(0, 1));
    bp_valid = 1'b0;
    if (bm == 1) begin
      @(posedge clk);
      #1 busy1 = 1'b1;
      repeat (10) @(posedge clk);
      #1 busy1 = 1'b0;
      // 2 sync flops + 1 decision edge, then SH_B low cycles; +1 for the next negedge sample
      bp_rise = cyc + 4 + SH_B;
      bp_valid = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    rdy0 = (force0 < 0) ? 1'($urandom_range(0, 1)) : force0[0];
    rdy1 = (force1 < 0) ? 1'($urandom_range(0, 1)) : force1[0];
  end

  // Monitor: cnv width, shift start latency, scki phase widths, word contents and stability
  int cnv_run[2], hi_run[2], lo_run[2], rises[2], exp_rise[2], delivered[2];
  logic p_scki[2], p_cnv[2], p_dv[2];
  logic [23:0] held[2];
  logic [23:0] m_e;
  logic m_have, m_r;
  int m_sh;

  initial begin
    for (int c = 0; c < 2; c++) begin
      delivered[c] = 0;
      exp_rise[c] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < 2; c++) begin
      m_sh = (c == 1) ? SH_B : SH_A;
      if (!rst_n) begin
        cnv_run[c] = 0; hi_run[c] = 0; lo_run[c] = 0; rises[c] = 0;
        p_scki[c] = 1'b0; p_cnv[c] = 1'b0; p_dv[c] = 1'b0;
      end else begin
        if (cnv_w[c]) cnv_run[c]++;
        else if (p_cnv[c]) begin
          chk($sformatf("cnv_width%0d", c), 32'(cnv_run[c]), 32'd2);
          cnv_run[c] = 0;
          rises[c] = 0;
          exp_rise[c] = cyc + ((c == 1) ? 2 * TN : TN) + m_sh;
        end
        if (scki_w[c]) begin
          if (!p_scki[c]) begin
            rises[c]++;
            if (rises[c] == 1)
              chk($sformatf("shift_start%0d", c), 32'(cyc),
                  32'((c == 1 && bp_valid) ? bp_rise : exp_rise[c]));
            else
              chk($sformatf("scki_low%0d", c), 32'(lo_run[c]), 32'(m_sh));
            hi_run[c] = 0;
          end
          hi_run[c]++;
        end else begin
          if (p_scki[c]) begin
            chk($sformatf("scki_high%0d", c), 32'(hi_run[c]), 32'(m_sh));
            lo_run[c] = 0;
          end
          lo_run[c]++;
        end
        if (dv_w[c] && !p_dv[c]) begin
          chk($sformatf("scki_pulses%0d", c), 32'(rises[c]), 32'd24);
          m_have = (c == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          chk($sformatf("word_expected%0d", c), 32'(m_have), 32'd1);
          if (m_have) begin
            m_e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("word%0d", c), 32'(dout_w[c]), 32'(m_e));
          end
          held[c] = dout_w[c];
        end else if (dv_w[c]) begin
          chk($sformatf("dout_stable%0d", c), 32'(dout_w[c]), 32'(held[c]));
        end
        if (dv_w[c]) chk($sformatf("no_cnv_while_valid%0d", c), 32'(cnv_w[c]), 32'd0);
        m_r = (c == 0) ? rdy0 : rdy1;
        if (dv_w[c] && m_r) delivered[c]++;
        p_scki[c] = scki_w[c];
        p_cnv[c] = cnv_w[c];
        p_dv[c] = dv_w[c];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic ok, saw;
  int d0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rst_cnv%0d", c), 32'(cnv_w[c]), 32'd0);
      chk($sformatf("rst_scki%0d", c), 32'(scki_w[c]), 32'd0);
      chk($sformatf("rst_dout%0d", c), 32'(dout_w[c]), 32'd0);
      chk($sformatf("rst_valid%0d", c), 32'(dv_w[c]), 32'd0);
    end
    #3 rst_n = 1'b1;

    // Instance A: known word, consumer stalls 100 cycles, then a single-cycle ready
    adc_q0.push_back(24'hABCDE5);
    force0 = 0;
    en0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); ok = dv_w[0]; end
    chk("wait_first_valid", 32'(ok), 32'd1);
    repeat (100) @(posedge clk);
    force0 = 1;
    @(posedge clk);
    force0 = 0;
    @(negedge clk);
    chk("hs_valid_cleared", 32'(dv_w[0]), 32'd0);
    chk("hs_cnv_restart", 32'(cnv_w[0]), 32'd1);

    // Random words with random backpressure
    force0 = -1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); ok = (delivered[0] >= 6); end
    chk("wait_random_words", 32'(ok), 32'd1);

    // Reset in the middle of bit 12, then a clean word
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (rises[0] == 12) && scki_w[0];
    end
    chk("wait_bit12", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_scki", 32'(scki_w[0]), 32'd0);
    chk("midreset_valid", 32'(dv_w[0]), 32'd0);
    chk("midreset_cnv", 32'(cnv_w[0]), 32'd0);
    exp_q0.delete();
    adc_q0.delete();
    adc_q0.push_back(24'h3FFFF8);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    d0 = delivered[0];
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); ok = (delivered[0] > d0); end
    chk("wait_after_reset_word", 32'(ok), 32'd1);

    // Drop enable during WAIT: the word still arrives, then the block idles
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); ok = cnv_w[0]; end
    for (int i = 0; i < 10 && ok; i++) begin @(negedge clk); ok = cnv_w[0]; end
    chk("wait_cnv_fall", 32'(ok), 32'd0);
    repeat (5) @(posedge clk);
    en0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (exp_q0.size() == 0) && !dv_w[0];
    end
    chk("drain_after_disable", 32'(ok), 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); saw = saw | cnv_w[0]; end
    chk("idle_after_disable", 32'(saw), 32'd0);

    // Instance B: BUSY mode, SCK_HALF = 3, directed patterns then random
    adc_q1.push_back(24'h000000);
    adc_q1.push_back(24'hFFFFFF);
    adc_q1.push_back(24'h800001);
    bmode_q.push_back(1);
    bmode_q.push_back(0);
    bmode_q.push_back(1);
    force1 = -1;
    en1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin @(negedge clk); ok = (delivered[1] >= 5); end
    chk("wait_b_words", 32'(ok), 32'd5 > 0 ? 32'd1 : 32'd0);
    en1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (exp_q1.size() == 0) && !dv_w[1];
    end
    chk("drain_b", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);

    chk("queue_empty_a", 32'(exp_q0.size()), 32'd0);
    chk("queue_empty_b", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
